sub_result_stage: RTL
=====================

SUB_RESULT_STAGE -- requirements
Module: sub_result_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width; the diff input is WIDTH+1 bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the saturating borrow and error counters.
REQ-003 Port clk, input, 1 bit: single clock, rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: the upstream subtractor result is valid.
REQ-006 Port in_ready, output, 1 bit: the stage can accept a result this cycle.
REQ-007 Port a and port b, inputs, WIDTH bits each: the operands fed to the subtractor.
REQ-008 Port diff, input, WIDTH+1 bits: the subtractor output; diff[WIDTH-1:0] is a-b mod 2^WIDTH and diff[WIDTH] is the borrow (1 when a<b unsigned).
REQ-009 Port out_valid, output, 1 bit: the output entry is valid.
REQ-010 Port out_ready, input, 1 bit: downstream accepts the output entry.
REQ-011 Port out_diff, output, WIDTH bits: the registered diff[WIDTH-1:0].
REQ-012 Ports out_zero, out_borrow, out_neg, out_ovf, out_lt_s, outputs, 1 bit each: the flags of the output entry.
REQ-013 Port out_chk_err, output, 1 bit: the captured diff disagrees with a-b recomputed locally.
REQ-014 Ports borrow_cnt and err_cnt, outputs, CNT_W bits each: saturating event counters.

Function
REQ-015 A transfer in SHALL occur when in_valid and in_ready are both 1; a transfer out SHALL occur when out_valid and out_ready are both 1.
REQ-016 The block SHALL buffer results in a 2-entry FIFO; in_ready SHALL be 1 exactly when occupancy is less than 2 (registered, no combinational path from out_ready).
REQ-017 Flags SHALL be computed at capture and stored with the entry:
- zero = (diff[WIDTH-1:0]==0)
- borrow = diff[WIDTH]
- neg = diff[WIDTH-1]
- ovf = (a[MSB]!=b[MSB]) and (diff[WIDTH-1]!=a[MSB])
- lt_s = neg XOR ovf
REQ-018 chk_err SHALL be 1 when {borrow, diff[WIDTH-1:0]} differs from the locally computed (WIDTH+1)-bit a-b, with borrow = (a<b unsigned).
REQ-019 Latency SHALL be 1 cycle: an entry captured into an empty FIFO at edge N SHALL appear on out_* with out_valid=1 after edge N.
REQ-020 out_* SHALL always present the oldest entry; out_* SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1, with the new entry becoming the head.
REQ-022 At occupancy 2, in_ready SHALL be 0 and a pop SHALL raise in_ready in the next cycle; no push SHALL be accepted in the same cycle as that pop.
REQ-023 A pop at occupancy 0 SHALL be impossible because out_valid=0; out_ready SHALL be ignored when out_valid=0.
REQ-024 Storage SHALL consist of the write pointer, the read pointer (1 bit each, wrapping 1->0) and a 2-bit occupancy count.
REQ-025 borrow_cnt SHALL increment on each accepted input with borrow=1 and saturate at 2^CNT_W-1.
REQ-026 err_cnt SHALL increment on each accepted input with chk_err=1 and saturate at 2^CNT_W-1.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear occupancy, both pointers, out_valid, all flags, out_diff, borrow_cnt and err_cnt to 0, and set in_ready to 0.
REQ-028 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-029 Reset during a transfer SHALL discard all buffered entries; no partial entry SHALL remain.

Verification
REQ-030 a=60003, b=43839, diff=16164 -> out_diff=16164, borrow=0, zero=0, neg=0, ovf=0, chk_err=0, one cycle after accept.
REQ-031 a=24485, b=56623, diff={1,33398} -> out_diff=33398, borrow=1, neg=1, ovf=1, lt_s=0, borrow_cnt increments by 1.
REQ-032 a=765, b=765, diff=0 -> zero=1, borrow=0, lt_s=0; a=765, b=17406, diff with bit 0 flipped -> chk_err=1, err_cnt increments by 1.
REQ-033 out_ready=0 while 3 valid inputs are driven -> 2 are accepted, in_ready=0 on the 3rd, out_* stable; then out_ready=1 -> entries emerge in order with no loss or duplication.
REQ-034 255 borrowing inputs followed by 2 more -> borrow_cnt holds at 255; rst_n pulsed low mid-stream -> all outputs 0 immediately and FIFO empty.

Source files
------------

// File: rtl/sub_result_if.sv
// Handshake and data bundle between a subtractor, the result stage and its consumer.
// The slave side is the result stage; the master side drives operands and
// accepts finished entries.
interface sub_result_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);

  // Upstream side: subtractor result and the operands it was computed from
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   diff;

  // Downstream side: oldest buffered entry and its flags
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_zero;
  logic             out_borrow;
  logic             out_neg;
  logic             out_ovf;
  logic             out_lt_s;
  logic             out_chk_err;

  // Running event counters
  logic [CNT_W-1:0] borrow_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  diff,
    output out_valid,
    input  out_ready,
    output out_diff,
    output out_zero,
    output out_borrow,
    output out_neg,
    output out_ovf,
    output out_lt_s,
    output out_chk_err,
    output borrow_cnt,
    output err_cnt
  );

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output diff,
    input  out_valid,
    output out_ready,
    input  out_diff,
    input  out_zero,
    input  out_borrow,
    input  out_neg,
    input  out_ovf,
    input  out_lt_s,
    input  out_chk_err,
    input  borrow_cnt,
    input  err_cnt
  );

endinterface

// File: rtl/sub_result_stage.sv
// Result stage behind a WIDTH-bit subtractor. Each accepted result is tagged
// with zero/borrow/sign/overflow/signed-less-than flags plus a self-check bit
// (diff recomputed locally from a and b), then held in a 2-entry FIFO whose
// head is presented downstream. in_ready is registered so there is no
// combinational path from out_ready back upstream. Borrow and self-check
// failures are counted in saturating counters.
module sub_result_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sub_result_if.slave  io
);

  // One buffered entry: low diff bits plus the flags derived at capture time
  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             zero;
    logic             borrow;
    logic             neg;
    logic             ovf;
    logic             lt_s;
    logic             chk_err;
  } entry_t;

  // Builds the entry for a captured result. The overflow rule is the usual
  // two's-complement one: operands of opposite sign and a result whose sign
  // differs from the minuend. lt_s is the signed comparison a<b derived from
  // the subtraction. The self-check recomputes the (WIDTH+1)-bit unsigned
  // difference, whose top bit is the borrow, and compares it with what the
  // subtractor delivered.
  function automatic entry_t make_entry(
    input logic [WIDTH-1:0] op_a,
    input logic [WIDTH-1:0] op_b,
    input logic [WIDTH:0]   sub_diff
  );
    entry_t               e;
    logic signed [WIDTH:0] ref_diff;
    ref_diff  = $signed({1'b0, op_a}) - $signed({1'b0, op_b});
    e.diff    = sub_diff[WIDTH-1:0];
    e.zero    = (sub_diff[WIDTH-1:0] == '0);
    e.borrow  = sub_diff[WIDTH];
    e.neg     = sub_diff[WIDTH-1];
    e.ovf     = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                (sub_diff[WIDTH-1] != op_a[WIDTH-1]);
    e.lt_s    = e.neg ^ e.ovf;
    e.chk_err = (sub_diff != $unsigned(ref_diff));
    return e;
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] cnt,
    input logic             en
  );
    logic [CNT_W-1:0] res;
    res = cnt;
    if (en && (cnt != {CNT_W{1'b1}})) begin
      res = cnt + CNT_W'(1);
    end
    return res;
  endfunction

  // Capture stage (p0): flags computed combinationally from the live inputs
  entry_t     cap_p0;
  logic       push;
  logic       pop;
  logic [1:0] occ_next;
  logic       in_ready_next;

  // FIFO storage (p1) and its control state
  entry_t           ent_p1 [2];
  entry_t           head_p1;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic             in_ready_q;
  logic [CNT_W-1:0] borrow_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  // Transfer decode, next occupancy and next in_ready
  always_comb begin
    cap_p0        = make_entry(io.a, io.b, io.diff);
    push          = io.in_valid && in_ready_q;
    pop           = (occ != 2'd0) && io.out_ready;
    occ_next      = occ;
    in_ready_next = 1'b1;
    case ({push, pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
    // At occupancy 2 in_ready is low, so a pop there cannot coincide with a
    // push; in_ready comes back one cycle after that pop.
    in_ready_next = (occ_next != 2'd2);
  end

  // Pointer, occupancy and ready registers; in_ready stays low through reset
  // and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      occ        <= occ_next;
      in_ready_q <= in_ready_next;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // ---- stage boundary p0 -> p1: captured entry written into the FIFO ----
  // Entry storage; cleared on reset so the presented head reads as all zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ent_p1[i] <= '0;
      end
    end else if (push) begin
      ent_p1[wr_ptr] <= cap_p0;
    end
  end

  // Saturating event counters, advanced only by accepted inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      borrow_cnt_q <= sat_inc(borrow_cnt_q, push && cap_p0.borrow);
      err_cnt_q    <= sat_inc(err_cnt_q, push && cap_p0.chk_err);
    end
  end

  // Output side: the oldest entry is always the one under the read pointer,
  // so it holds still until it is popped
  assign head_p1        = ent_p1[rd_ptr];
  assign io.in_ready    = in_ready_q;
  assign io.out_valid   = (occ != 2'd0);
  assign io.out_diff    = head_p1.diff;
  assign io.out_zero    = head_p1.zero;
  assign io.out_borrow  = head_p1.borrow;
  assign io.out_neg     = head_p1.neg;
  assign io.out_ovf     = head_p1.ovf;
  assign io.out_lt_s    = head_p1.lt_s;
  assign io.out_chk_err = head_p1.chk_err;
  assign io.borrow_cnt  = borrow_cnt_q;
  assign io.err_cnt     = err_cnt_q;

endmodule
